swc_ll_access_arbiter: RTL and testbench

Shares one single-port linked-list RAM between NUM_PORTS ports. Each port has four request classes: page write, page free, read-pump read and free-pck read. The block arbitrates round-robin, issues at most one RAM access per cycle, and returns one-cycle done strobes plus read data. It sits between the per-port page logic and the linked-list RAM inside swc_multiport_linked_list.

---
 rtl/swc_ll_access_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_swc_ll_access_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/swc_ll_access_arbiter.sv
// Round-robin arbiter sharing one single-port linked-list RAM between NUM_PORTS ports.
// Optional `SWC_LL_ARB_WRITE_PRIO_EN: writes/frees win over reads (two-level round-robin).
module swc_ll_access_arbiter #(
  parameter int unsigned NUM_PORTS      = 11,
  parameter int unsigned PAGE_ADDR_BITS = 10
) (
  input  logic                                clk_i,
  input  logic                                rst_n_i,
  input  logic [NUM_PORTS-1:0]                write_i,
  input  logic [NUM_PORTS-1:0]                free_i,
  input  logic [NUM_PORTS-1:0]                read_pump_read_i,
  input  logic [NUM_PORTS-1:0]                free_pck_read_i,
  input  logic [NUM_PORTS*PAGE_ADDR_BITS-1:0] write_addr_i,
  input  logic [NUM_PORTS*PAGE_ADDR_BITS-1:0] write_data_i,
  input  logic [NUM_PORTS*PAGE_ADDR_BITS-1:0] free_addr_i,
  input  logic [NUM_PORTS*PAGE_ADDR_BITS-1:0] read_pump_addr_i,
  input  logic [NUM_PORTS*PAGE_ADDR_BITS-1:0] free_pck_addr_i,
  output logic [NUM_PORTS-1:0]                write_done_o,
  output logic [NUM_PORTS-1:0]                free_done_o,
  output logic [NUM_PORTS-1:0]                read_pump_read_done_o,
  output logic [NUM_PORTS-1:0]                free_pck_read_done_o,
  output logic [PAGE_ADDR_BITS-1:0]           data_o,
  output logic [PAGE_ADDR_BITS-1:0]           mem_addr_o,
  output logic                                mem_we_o,
  output logic [PAGE_ADDR_BITS-1:0]           mem_wdata_o,
  input  logic [PAGE_ADDR_BITS-1:0]           mem_rdata_i
);
  localparam int unsigned NumReq = 4 * NUM_PORTS;
  localparam int unsigned Half   = 2 * NUM_PORTS;
  localparam int unsigned IdxW   = $clog2(NumReq);
  localparam int unsigned W      = PAGE_ADDR_BITS;

  logic [NumReq-1:0] req, elig, gnt_oh, pending_q, pending_d, done_q, done_d;
  logic              gnt_valid;
  logic [IdxW-1:0]   gnt_idx;
  logic [W-1:0]      sel_addr, sel_wdata;
  logic              sel_we;
  logic              iss_valid_q;
  logic [IdxW-1:0]   iss_idx_q;
  logic [W-1:0]      mem_addr_q, mem_wdata_q, data_q;
  logic              mem_we_q;
  logic              rd_done;

  assign req  = {free_pck_read_i, read_pump_read_i, free_i, write_i};
  assign elig = req & ~pending_q;

  // Returns {found, index}: first set bit of v[base +: size] searching upward from base+ptr.
  function automatic logic [IdxW:0] rr_pick(input logic [NumReq-1:0] v, input int unsigned base,
                                            input int unsigned size, input int unsigned ptr);
    logic            found;
    logic [IdxW-1:0] idx, jj;
    found = 1'b0;
    idx   = '0;
    jj    = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      if (k < size) begin
        jj = IdxW'(base + (ptr + k) % size);
        if (!found && v[jj]) begin
          found = 1'b1;
          idx   = jj;
        end
      end
    end
    return {found, idx};
  endfunction

`ifdef SWC_LL_ARB_WRITE_PRIO_EN
  localparam int unsigned HalfW = $clog2(Half);
  logic [HalfW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [IdxW:0]    wpick, rpick;

  always_comb begin
    wpick     = rr_pick(elig, 0, Half, 32'(wptr_q));
    rpick     = rr_pick(elig, Half, Half, 32'(rptr_q));
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    if (wpick[IdxW]) begin
      gnt_valid = 1'b1;
      gnt_idx   = wpick[IdxW-1:0];
      wptr_d    = HalfW'((32'(gnt_idx) + 32'd1) % Half);
    end else if (rpick[IdxW]) begin
      gnt_valid = 1'b1;
      gnt_idx   = rpick[IdxW-1:0];
      rptr_d    = HalfW'((32'(gnt_idx) - Half + 32'd1) % Half);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end
`else
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW:0]   pick;

  always_comb begin
    pick      = rr_pick(elig, 0, NumReq, 32'(ptr_q));
    gnt_valid = pick[IdxW];
    gnt_idx   = pick[IdxW-1:0];
    ptr_d     = ptr_q;
    if (gnt_valid) ptr_d = IdxW'((32'(gnt_idx) + 32'd1) % NumReq);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end
`endif

  // Select the winner's address/data; frees write the all-ones null marker.
  always_comb begin
    int unsigned port;
    int unsigned cls;
    port      = 32'(gnt_idx) % NUM_PORTS;
    cls       = 32'(gnt_idx) / NUM_PORTS;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    case (cls)
      0: begin
        sel_addr  = write_addr_i[port*W +: W];
        sel_wdata = write_data_i[port*W +: W];
        sel_we    = 1'b1;
      end
      1: begin
        sel_addr  = free_addr_i[port*W +: W];
        sel_wdata = '1;
        sel_we    = 1'b1;
      end
      2:       sel_addr = read_pump_addr_i[port*W +: W];
      3:       sel_addr = free_pck_addr_i[port*W +: W];
      default: sel_addr = '0;
    endcase
  end

  always_comb begin
    gnt_oh    = gnt_valid ? (NumReq'(1) << gnt_idx) : '0;
    done_d    = iss_valid_q ? (NumReq'(1) << iss_idx_q) : '0;
    pending_d = (pending_q & ~done_q) | gnt_oh;
  end

  assign rd_done = |done_q[NumReq-1:Half];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pending_q   <= '0;
      done_q      <= '0;
      iss_valid_q <= 1'b0;
      iss_idx_q   <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      data_q      <= '0;
    end else begin
      pending_q   <= pending_d;
      done_q      <= done_d;
      iss_valid_q <= gnt_valid;
      iss_idx_q   <= gnt_idx;
      mem_we_q    <= gnt_valid & sel_we;
      if (gnt_valid) mem_addr_q <= sel_addr;
      if (gnt_valid && sel_we) mem_wdata_q <= sel_wdata;
      if (rd_done) data_q <= mem_rdata_i;
    end
  end

  assign write_done_o          = done_q[0*NUM_PORTS +: NUM_PORTS];
  assign free_done_o           = done_q[1*NUM_PORTS +: NUM_PORTS];
  assign read_pump_read_done_o = done_q[2*NUM_PORTS +: NUM_PORTS];
  assign free_pck_read_done_o  = done_q[3*NUM_PORTS +: NUM_PORTS];
  assign data_o                = rd_done ? mem_rdata_i : data_q;
  assign mem_addr_o            = mem_addr_q;
  assign mem_we_o              = mem_we_q;
  assign mem_wdata_o           = mem_wdata_q;
endmodule

// File: tb/tb_swc_ll_access_arbiter.sv
// Randomized self-checking bench for swc_ll_access_arbiter against a transaction-level model.
module tb_swc_ll_access_arbiter;
  localparam int N = 11;
  localparam int W = 10;
  localparam int R = 4 * N;

  logic clk_i = 1'b0;
  logic rst_n_i = 1'b0;
  logic [N-1:0]   write_i = '0, free_i = '0, read_pump_read_i = '0, free_pck_read_i = '0;
  logic [N*W-1:0] write_addr_i = '0, write_data_i = '0, free_addr_i = '0;
  logic [N*W-1:0] read_pump_addr_i = '0, free_pck_addr_i = '0;
  logic [N-1:0]   write_done_o, free_done_o, read_pump_read_done_o, free_pck_read_done_o;
  logic [W-1:0]   data_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic           mem_we_o;

  swc_ll_access_arbiter #(.NUM_PORTS(N), .PAGE_ADDR_BITS(W)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .write_i(write_i), .free_i(free_i), .read_pump_read_i(read_pump_read_i),
    .free_pck_read_i(free_pck_read_i),
    .write_addr_i(write_addr_i), .write_data_i(write_data_i), .free_addr_i(free_addr_i),
    .read_pump_addr_i(read_pump_addr_i), .free_pck_addr_i(free_pck_addr_i),
    .write_done_o(write_done_o), .free_done_o(free_done_o),
    .read_pump_read_done_o(read_pump_read_done_o), .free_pck_read_done_o(free_pck_read_done_o),
    .data_o(data_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Environment RAM: registered read, data valid the cycle after the address.
  logic [W-1:0] ram [1024];
  always @(posedge clk_i) begin
    if (mem_we_o) ram[mem_addr_o] <= mem_wdata_o;
    mem_rdata_i <= ram[mem_addr_o];
  end

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Requester and reference-model state.
  bit           req_on [R];
  bit           busy   [R];
  logic [W-1:0] a_m    [R];
  logic [W-1:0] d_m    [R];
  logic [W-1:0] shadow [1024];
  int           ptr, wptr, rptr;
  bit           iss_v, iss_we, dn_v, rel_v, keep_pump0;
  int           iss_idx, dn_idx, rel_idx, rand_pct;
  logic [W-1:0] iss_addr, iss_wdata, iss_rdata, dn_data, hold_data, last_addr, last_wdata;

  task automatic model_reset();
    ptr = 0; wptr = 0; rptr = 0;
    iss_v = 0; dn_v = 0; rel_v = 0;
    hold_data = '0; last_addr = '0; last_wdata = '0;
    for (int i = 0; i < R; i++) busy[i] = 0;
  endtask

  task automatic raise(input int idx, input logic [W-1:0] a, input logic [W-1:0] d);
    req_on[idx] = 1; a_m[idx] = a; d_m[idx] = d;
  endtask

  task automatic drive();
    for (int i = 0; i < R; i++) begin
      int p;
      p = i % N;
      case (i / N)
        0: begin
          write_i[p] = req_on[i]; write_addr_i[p*W +: W] = a_m[i]; write_data_i[p*W +: W] = d_m[i];
        end
        1: begin free_i[p] = req_on[i]; free_addr_i[p*W +: W] = a_m[i]; end
        2: begin read_pump_read_i[p] = req_on[i]; read_pump_addr_i[p*W +: W] = a_m[i]; end
        default: begin free_pck_read_i[p] = req_on[i]; free_pck_addr_i[p*W +: W] = a_m[i]; end
      endcase
    end
  endtask

  // Index of the winner among waiting requesters, or -1; advances the model pointers.
  function automatic int model_pick();
    int win;
    win = -1;
`ifdef SWC_LL_ARB_WRITE_PRIO_EN
    for (int k = 0; k < 2 * N; k++)
      if (win < 0 && req_on[(wptr + k) % (2 * N)] && !busy[(wptr + k) % (2 * N)])
        win = (wptr + k) % (2 * N);
    if (win >= 0) wptr = (win + 1) % (2 * N);
    else begin
      for (int k = 0; k < 2 * N; k++)
        if (win < 0 && req_on[2 * N + (rptr + k) % (2 * N)] && !busy[2 * N + (rptr + k) % (2 * N)])
          win = 2 * N + (rptr + k) % (2 * N);
      if (win >= 0) rptr = (win - 2 * N + 1) % (2 * N);
    end
`else
    for (int k = 0; k < R; k++)
      if (win < 0 && req_on[(ptr + k) % R] && !busy[(ptr + k) % R]) win = (ptr + k) % R;
    if (win >= 0) ptr = (win + 1) % R;
`endif
    return win;
  endfunction

  // One cycle, entered at posedge+1: check outputs, update requesters, arbitrate, advance.
  task automatic step();
    logic [R-1:0] exp_done;
    int win;
    exp_done = '0;
    if (dn_v) exp_done[dn_idx] = 1'b1;
    check_eq("done", {free_pck_read_done_o, read_pump_read_done_o, free_done_o, write_done_o},
             exp_done);
    check_eq("mem_we", mem_we_o, iss_v && iss_we);
    if (iss_v) begin
      last_addr = iss_addr;
      if (iss_we) last_wdata = iss_wdata;
    end
    check_eq("mem_addr", mem_addr_o, last_addr);
    check_eq("mem_wdata", mem_wdata_o, last_wdata);
    if (dn_v && dn_idx >= 2 * N) hold_data = dn_data;
    check_eq("data", data_o, hold_data);

    if (rel_v) begin req_on[rel_idx] = 0; busy[rel_idx] = 0; rel_v = 0; end
    if (dn_v) begin rel_v = 1; rel_idx = dn_idx; end
    for (int i = 0; i < R; i++)
      if (!req_on[i] && $urandom_range(99) < rand_pct)
        raise(i, W'($urandom_range(15)), W'($urandom_range(1023)));
    if (keep_pump0 && !req_on[2 * N]) raise(2 * N, W'(12), '0);
    drive();

    dn_v = iss_v; dn_idx = iss_idx; dn_data = iss_rdata;
    win = model_pick();
    iss_v = (win >= 0);
    if (iss_v) begin
      busy[win] = 1;
      iss_idx   = win;
      iss_we    = (win < 2 * N);
      iss_addr  = a_m[win];
      iss_wdata = (win < N) ? d_m[win] : '1;
      iss_rdata = shadow[iss_addr];
      if (iss_we) shadow[iss_addr] = iss_wdata;
    end
    @(posedge clk_i); #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int lat;
    int bound;
    for (int i = 0; i < 1024; i++) begin ram[i] = '0; shadow[i] = '0; end
    for (int i = 0; i < R; i++) begin req_on[i] = 0; a_m[i] = '0; d_m[i] = '0; end
    rand_pct = 0; keep_pump0 = 0;
    model_reset();
    drive();
    repeat (3) @(posedge clk_i);
    #1;
    check_eq("rst_done", {free_pck_read_done_o, read_pump_read_done_o, free_done_o, write_done_o},
             '0);
    check_eq("rst_we", mem_we_o, 1'b0);
    check_eq("rst_addr", mem_addr_o, '0);
    check_eq("rst_data", data_o, '0);
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;

    raise(3, W'(5), W'(5));                // write port 3
    run(4);
    raise(2 * N + 3, W'(5), '0);           // pump read port 3
    run(15);
    check_eq("data_held", data_o, W'(5));

    for (int p = 0; p < N; p++) raise(p, W'(p), W'(p));
    run(16);
    for (int p = 0; p < N; p++) check_eq("ram_fill", ram[p], W'(p));

    raise(N + 2, W'(7), '0);               // free port 2
    run(4);
    raise(3 * N + 4, W'(7), '0);           // free-pck read port 4
    run(5);
    check_eq("null_read", data_o, W'(10'h3FF));

    rand_pct = 30;
    run(2000);
    rand_pct = 0;
    run(40);

    // Reset mid-operation with three reads outstanding.
    raise(2 * N + 1, W'(2), '0);
    raise(2 * N + 6, W'(4), '0);
    raise(3 * N + 9, W'(9), '0);
    run(2);
    rst_n_i = 1'b0;
    #1;
    check_eq("amid_done", {free_pck_read_done_o, read_pump_read_done_o, free_done_o, write_done_o},
             '0);
    check_eq("amid_we", mem_we_o, 1'b0);
    check_eq("amid_data", data_o, '0);
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    model_reset();
    run(12);

    // Write under a continuously held pump read.
    keep_pump0 = 1;
    run(5);
    raise(5, W'(9), W'(3));
`ifdef SWC_LL_ARB_WRITE_PRIO_EN
    bound = 1;
`else
    bound = R + 1;
`endif
    lat = 0;
    while (lat < R + 4) begin
      step();
      lat++;
      if (mem_we_o && mem_addr_o == W'(9)) break;
    end
    check_eq("write_latency", (lat <= bound), 1'b1);
    keep_pump0 = 0;
    run(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
